// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS datapath with a shared ALU and shared memory.
// Moore outputs from state; pc_en/IRWrite also depend on mem_ready, zero and rst.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       ExtZero,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
        BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
        JAL    = 4'd12, JR     = 4'd13, TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t cur, nxt;
    logic   zext;

    assign state = cur;
    // Logical immediates use zero extension; IR is stable through IWB so no latch is needed.
    assign zext  = (opcode == OP_ORI) || (opcode == OP_LUI);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= FETCH;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == TRAP) illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt      = cur;
        pc_en    = 1'b0;
        PCSource = 2'b00;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        ExtZero  = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                pc_en   = mem_ready;
                if (mem_ready) nxt = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:                nxt = (funct == FN_JR) ? JR : EXEC;
                    OP_LW, OP_SW:            nxt = MEMADR;
                    OP_BEQ, OP_BNE:          nxt = BRANCH;
                    OP_ADDI, OP_ORI, OP_LUI: nxt = IEXEC;
                    OP_J:                    nxt = JUMP;
                    OP_JAL:                  nxt = JAL;
                    default:                 nxt = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) nxt = MEMWB;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                nxt      = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) nxt = FETCH;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                nxt      = FETCH;
            end
            BRANCH: begin
                // opcode[0] distinguishes bne from beq and inverts the taken sense
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                pc_en    = zero ^ opcode[0];
                nxt      = FETCH;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                ExtZero = zext;
                nxt     = IWB;
            end
            IWB: begin
                RegWrite = 1'b1;
                ExtZero  = zext;
                nxt      = FETCH;
            end
            JUMP: begin
                PCSource = 2'b10;
                pc_en    = 1'b1;
                nxt      = FETCH;
            end
            JAL: begin
                PCSource = 2'b10;
                pc_en    = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                nxt      = FETCH;
            end
            JR: begin
                PCSource = 2'b11;
                pc_en    = 1'b1;
                nxt      = FETCH;
            end
            TRAP:    nxt = TRAP;
            default: nxt = FETCH;
        endcase
        if (rst) begin
            pc_en   = 1'b0;
            IRWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: the driver expands each instruction into its expected cycle trace,
// a negedge monitor pops one expected observation per cycle and compares it to the DUT.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtZero, illegal;
    logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB, ALUOp;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtZero(ExtZero), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic [1:0] pcs;
        logic       iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r;
        logic       asa;
        logic [1:0] asb, aop;
        logic       ext, ill;
    } obs_t;

    typedef struct packed {
        obs_t       o;
        logic [7:0] tag;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08,
                           ORI = 6'h0d, LUI = 6'h0f, J = 6'h02, JAL_OP = 6'h03, RT = 6'h00;

    // Expected observation for one cycle, straight from the per-state output table.
    function automatic obs_t model(input int st, input logic [5:0] op, input logic z,
                                   input logic mr, input logic r);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0:  begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pc_en = mr; end
            1:  o.asb = 2'b11;
            2:  begin o.asa = 1; o.asb = 2'b10; end
            3:  begin o.mrd = 1; o.iord = 1; end
            4:  begin o.rw = 1; o.m2r = 2'b01; end
            5:  begin o.mwr = 1; o.iord = 1; end
            6:  begin o.asa = 1; o.aop = 2'b10; end
            7:  begin o.rw = 1; o.rdst = 2'b01; end
            8:  begin o.asa = 1; o.aop = 2'b01; o.pcs = 2'b01;
                      o.pc_en = (op == BEQ) ? z : !z; end
            9:  begin o.asa = 1; o.asb = 2'b10; o.aop = 2'b11; o.ext = (op == ORI || op == LUI); end
            10: begin o.rw = 1; o.ext = (op == ORI || op == LUI); end
            11: begin o.pcs = 2'b10; o.pc_en = 1; end
            12: begin o.pcs = 2'b10; o.pc_en = 1; o.rw = 1; o.rdst = 2'b10; o.m2r = 2'b10; end
            13: begin o.pcs = 2'b11; o.pc_en = 1; end
            15: o.ill = 1;
            default: ;
        endcase
        if (r) begin o.pc_en = 0; o.irw = 0; end
        return o;
    endfunction

    // One clock: drive inputs, queue what the DUT must show this cycle, advance.
    task automatic cyc(input int st, input logic mr, input logic r, input logic [7:0] tag);
        exp_t e;
        mem_ready = mr;
        rst = r;
        e.o = model(st, opcode, zero, mr, r);
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_access(input int st, input int waits, input logic [7:0] tag);
        for (int i = 0; i < waits; i++) cyc(st, 1'b0, 1'b0, tag);
        cyc(st, 1'b1, 1'b0, tag);
    endtask

    // Instruction-level reference: trace of states after fetch/decode.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input logic [7:0] tag);
        opcode = op;
        funct = fn;
        zero = z;
        mem_access(0, wf, tag);
        cyc(1, 1'($urandom), 1'b0, tag);
        case (op)
            LW:     begin cyc(2, 1'($urandom), 0, tag); mem_access(3, wm, tag); cyc(4, 1'($urandom), 0, tag); end
            SW:     begin cyc(2, 1'($urandom), 0, tag); mem_access(5, wm, tag); end
            RT:     if (fn == 6'h08) cyc(13, 1'($urandom), 0, tag);
                    else begin cyc(6, 1'($urandom), 0, tag); cyc(7, 1'($urandom), 0, tag); end
            BEQ, BNE: cyc(8, 1'($urandom), 0, tag);
            ADDI, ORI, LUI: begin cyc(9, 1'($urandom), 0, tag); cyc(10, 1'($urandom), 0, tag); end
            J:      cyc(11, 1'($urandom), 0, tag);
            JAL_OP: cyc(12, 1'($urandom), 0, tag);
            default: for (int i = 0; i < 10; i++) cyc(15, 1'($urandom), 0, tag);
        endcase
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            obs_t a;
            e = q.pop_front();
            a = '{state, pc_en, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtZero, illegal};
            n_chk++;
            if (a !== e.o) begin
                n_fail++;
                $display("FAIL cycle_obs tag=%0d t=%0t got=%h want=%h", e.tag, $time, a, e.o);
            end
        end
    end

    initial begin
        logic [5:0] ops [11];
        ops = '{RT, RT, LW, SW, BEQ, BNE, ADDI, ORI, LUI, J, JAL_OP};
        rst = 1; opcode = 0; funct = 0; zero = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, zero-wait fetch, then directed cases
        run_instr(RT, 6'h20, 0, 0, 0, 8'd1);
        run_instr(LW, 6'h00, 0, 2, 2, 8'd2);
        run_instr(BEQ, 6'h00, 1, 0, 0, 8'd3);
        run_instr(BNE, 6'h00, 1, 0, 0, 8'd4);
        run_instr(JAL_OP, 6'h00, 0, 0, 0, 8'd5);
        run_instr(RT, 6'h08, 0, 1, 0, 8'd6);
        run_instr(ORI, 6'h00, 0, 0, 0, 8'd7);
        run_instr(ADDI, 6'h00, 0, 0, 0, 8'd8);
        // Randomized instruction mix
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 8'(100 + i));
        end
        // Reset during a stalled store
        opcode = SW; funct = 0;
        mem_access(0, 0, 8'd20);
        cyc(1, 1'b1, 0, 8'd20);
        cyc(2, 1'b1, 0, 8'd20);
        cyc(5, 1'b0, 0, 8'd20);
        cyc(5, 1'b0, 1, 8'd20);
        cyc(0, 1'b0, 0, 8'd21);
        cyc(0, 1'b1, 0, 8'd21);
        cyc(1, 1'b1, 0, 8'd21);
        cyc(2, 1'b1, 0, 8'd21);
        mem_access(5, 1, 8'd21);
        // Illegal opcode: trap, then reset clears the flag
        run_instr(6'h3f, 6'h00, 0, 0, 0, 8'd30);
        cyc(15, 1'b1, 1, 8'd31);
        run_instr(J, 6'h00, 0, 0, 0, 8'd32);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
